// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: access widths, FSM states,
// the latched request bundle and a width-to-byte-lane helper.
package dmem_responder_pkg;

   localparam int DMEM_DW = 64;

   typedef enum logic [1:0] {MW_B, MW_H, MW_W, MW_D} mem_width_e;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;

   typedef struct packed {
      logic               we;
      logic [DMEM_DW-1:0] addr;
      logic [DMEM_DW-1:0] wdata;
      mem_width_e         width;
      logic               is_unsigned;
   } DMEM_Req_t;

   // One bit per byte lane touched by an access of the given width.
   function automatic logic [7:0] width_lane_mask(mem_width_e w);
      case (w)
         MW_B:    return 8'h01;
         MW_H:    return 8'h03;
         MW_W:    return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/dmem_responder_byte_array.sv
// Byte-addressed storage: eight combinational read lanes at addr..addr+7 and
// eight individually enabled write lanes committed on the rising edge.
module dmem_byte_array #(
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk_i,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [7:0]            i_wr_en,
   input  logic [63:0]           i_wr_data,
   output logic [63:0]           o_rd_data
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [7:0] r_mem [0:DEPTH-1];

   // Read lanes: byte k of the result is the byte at i_addr + k.
   always_comb begin
      for (int k = 0; k < 8; k++) begin
         o_rd_data[8*k +: 8] = r_mem[i_addr + ADDR_WIDTH'(k)];
      end
   end

   // Write lanes: each enabled lane stores its byte of i_wr_data.
   // NOTE: storage has no reset; clearing an array costs a reset net per bit and contents are undefined by design.
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < 8; k++) begin
         if (i_wr_en[k]) begin
            r_mem[i_addr + ADDR_WIDTH'(k)] <= i_wr_data[8*k +: 8];
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY
// edges (counting the accept edge), then performs the access and holds the
// extended load data / store acknowledge until the requester takes it.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 64,
   parameter int LATENCY    = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [DATA_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   input  logic [1:0]            req_width_i,
   input  logic                  req_unsigned_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_err_o
);

   dmem_state_e r_state, w_state_nxt;
   logic [3:0]  r_cnt, w_cnt_nxt;
   DMEM_Req_t   r_req, w_in_req, w_cur_req;
   logic        r_rsp_valid;
   logic [63:0] r_rdata, w_rdata_nxt;
   logic        r_err, w_err_nxt;
   logic        w_accept, w_enter_resp;
   logic [7:0]  w_lane_mask, w_wr_en;
   logic [2:0]  w_align_mask;
   logic        w_sign_fill;
   logic [63:0] w_rd_bytes, w_ext;

   assign req_ready_o = (r_state == IDLE);
   assign w_accept    = req_valid_i && req_ready_o;

   // Request view: live inputs while idle (so LATENCY=1 can complete on the
   // accept edge), the latched copy otherwise.
   always_comb begin
      w_in_req = '{we: req_we_i, addr: req_addr_i, wdata: req_wdata_i,
                   width: mem_width_e'(req_width_i), is_unsigned: req_unsigned_i};
      w_cur_req = (r_state == IDLE) ? w_in_req : r_req;
   end

   // Next-state and wait-counter logic.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (LATENCY == 1) begin
                  w_state_nxt = RESP;
               end else begin
                  w_state_nxt = WAIT;
                  w_cnt_nxt   = 4'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) w_state_nxt = RESP;
         end
         RESP: begin
            if (rsp_ready_i) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      w_enter_resp = (r_state != RESP) && (w_state_nxt == RESP);
   end

   dmem_byte_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
      .clk_i     (clk_i),
      .i_addr    (w_cur_req.addr[ADDR_WIDTH-1:0]),
      .i_wr_en   (w_wr_en),
      .i_wr_data (w_cur_req.wdata),
      .o_rd_data (w_rd_bytes)
   );

   // Access result: error check, load extension and store lane enables.
   always_comb begin
      w_lane_mask  = width_lane_mask(w_cur_req.width);
      w_align_mask = 3'((8'd1 << w_cur_req.width) - 8'd1);
      w_err_nxt    = (|(w_cur_req.addr[2:0] & w_align_mask)) ||
                     (|w_cur_req.addr[DMEM_DW-1:ADDR_WIDTH]);
      case (w_cur_req.width)
         MW_B:    w_sign_fill = w_rd_bytes[7];
         MW_H:    w_sign_fill = w_rd_bytes[15];
         MW_W:    w_sign_fill = w_rd_bytes[31];
         default: w_sign_fill = 1'b0;
      endcase
      w_sign_fill = w_sign_fill && !w_cur_req.is_unsigned;
      for (int k = 0; k < 8; k++) begin
         w_ext[8*k +: 8] = w_lane_mask[k] ? w_rd_bytes[8*k +: 8] : {8{w_sign_fill}};
      end
      w_rdata_nxt = (w_err_nxt || w_cur_req.we) ? 64'd0 : w_ext;
      // A reset on the commit edge discards the store.
      w_wr_en = (w_enter_resp && w_cur_req.we && !w_err_nxt && !rst_i) ? w_lane_mask : 8'h00;
   end

   // State, counter, request latch and registered response.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= IDLE;
         r_cnt       <= 4'd0;
         r_rsp_valid <= 1'b0;
         r_rdata     <= 64'd0;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_enter_resp) begin
            r_rsp_valid <= 1'b1;
            r_rdata     <= w_rdata_nxt;
            r_err       <= w_err_nxt;
         end else if (r_state == RESP && rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_rdata     <= 64'd0;
            r_err       <= 1'b0;
         end
      end
   end

   // Request latch carries no reset; it is only read after an accept.
   always_ff @(posedge clk_i) begin
      if (w_accept) r_req <= w_in_req;
   end

   assign rsp_valid_o = r_rsp_valid;
   assign rsp_rdata_o = r_rdata;
   assign rsp_err_o   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed test-plan cases plus
// randomized traffic checked against a byte-array reference model.
module tb_dmem_responder;

   localparam int ADDR_WIDTH = 12;
   localparam int DATA_WIDTH = 64;
   localparam int LATENCY    = 2;
   localparam int MEM_BYTES  = 1 << ADDR_WIDTH;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_we_i = 1'b0;
   logic [63:0] req_addr_i = '0;
   logic [63:0] req_wdata_i = '0;
   logic [1:0]  req_width_i = '0;
   logic        req_unsigned_i = 1'b0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b1;
   logic [63:0] rsp_rdata_o;
   logic        rsp_err_o;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] m_mem [0:MEM_BYTES-1];

   always #5 clk_i = ~clk_i;

   dmem_responder #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .LATENCY(LATENCY)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_we_i       (req_we_i),
      .req_addr_i     (req_addr_i),
      .req_wdata_i    (req_wdata_i),
      .req_width_i    (req_width_i),
      .req_unsigned_i (req_unsigned_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_ready_i    (rsp_ready_i),
      .rsp_rdata_o    (rsp_rdata_o),
      .rsp_err_o      (rsp_err_o)
   );

   // Reference model: an access of 2^w bytes, little-endian, with sign
   // extension done arithmetically by subtracting 2^bits.
   task automatic model_access(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                               input int w, input logic uns,
                               output logic exp_err, output logic [63:0] exp_rdata);
      int n;
      int bits;
      longint unsigned v;
      n         = 1 << w;
      bits      = 8 * n;
      exp_err   = ((addr % 64'(n)) != 0) || (addr >= 64'(MEM_BYTES));
      exp_rdata = '0;
      if (exp_err) return;
      if (we) begin
         for (int i = 0; i < n; i++) m_mem[int'(addr) + i] = wdata[8*i +: 8];
      end else begin
         v = 0;
         for (int i = 0; i < n; i++) v = v + (longint'(m_mem[int'(addr) + i]) << (8 * i));
         if (!uns && n < 8 && ((v >> (bits - 1)) & 1) == 1) v = v - (64'd1 << bits);
         exp_rdata = v;
      end
   endtask

   task automatic drive_req(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                            input int w, input logic uns);
      req_valid_i    = 1'b1;
      req_we_i       = we;
      req_addr_i     = addr;
      req_wdata_i    = wdata;
      req_width_i    = 2'(w);
      req_unsigned_i = uns;
   endtask

   // One full transaction with rsp_ready_i high; checks latency, response
   // fields against the model and the return to idle.
   task automatic run_txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                          input int w, input logic uns, input string name,
                          output logic [63:0] got_rdata, output logic got_err);
      logic        e_err;
      logic [63:0] e_rd;
      int          lat;
      bit          seen;
      model_access(we, addr, wdata, w, uns, e_err, e_rd);
      @(negedge clk_i);
      drive_req(we, addr, wdata, w, uns);
      n_cmp++;
      if (req_ready_o !== 1'b1) begin
         n_bad++;
         $display("FAIL %s ready_before_accept: got %b want 1", name, req_ready_o);
      end
      @(posedge clk_i);
      #1 req_valid_i = 1'b0;
      lat  = 1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_i);
         if (rsp_valid_o === 1'b1) begin
            seen = 1;
            break;
         end
         @(posedge clk_i);
         lat++;
      end
      n_cmp++;
      if (!seen || lat != LATENCY) begin
         n_bad++;
         $display("FAIL %s latency: got %0d (seen=%0d) want %0d", name, lat, seen, LATENCY);
      end
      got_rdata = rsp_rdata_o;
      got_err   = rsp_err_o;
      n_cmp++;
      if (rsp_err_o !== e_err || rsp_rdata_o !== e_rd) begin
         n_bad++;
         $display("FAIL %s response: got err=%b rdata=%h want err=%b rdata=%h",
                  name, rsp_err_o, rsp_rdata_o, e_err, e_rd);
      end
      @(negedge clk_i);
      n_cmp++;
      if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || rsp_rdata_o !== 64'd0 || rsp_err_o !== 1'b0) begin
         n_bad++;
         $display("FAIL %s after_handshake: got valid=%b ready=%b rdata=%h err=%b want 0 1 0 0",
                  name, rsp_valid_o, req_ready_o, rsp_rdata_o, rsp_err_o);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      n_cmp++;
      if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || rsp_rdata_o !== 64'd0 || rsp_err_o !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_values: got ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
                  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o);
      end
      rst_i = 1'b0;
   endtask

   // Fill 0x000..0x3FF with random doubles so later loads have known data.
   task automatic test_fill();
      logic [63:0] rd;
      logic        er;
      for (int a = 0; a < 1024; a += 8) begin
         run_txn(1'b1, 64'(a), {$urandom, $urandom}, 3, 1'b0, "fill", rd, er);
      end
   endtask

   typedef struct {
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
      int          w;
      logic        uns;
      logic [63:0] exp_rdata;
      logic        exp_err;
      string       name;
   } dir_t;

   task automatic test_directed();
      dir_t        t [11];
      logic [63:0] rd;
      logic        er;
      t[0]  = '{1'b1, 64'h100,  64'h8877665544332211, 3, 1'b0, 64'h0,                 1'b0, "sd_0x100"};
      t[1]  = '{1'b0, 64'h100,  64'h0,                3, 1'b0, 64'h8877665544332211,  1'b0, "ld_0x100"};
      t[2]  = '{1'b0, 64'h107,  64'h0,                0, 1'b0, 64'hFFFFFFFFFFFFFF88,  1'b0, "lb_0x107"};
      t[3]  = '{1'b0, 64'h107,  64'h0,                0, 1'b1, 64'h88,                1'b0, "lbu_0x107"};
      t[4]  = '{1'b0, 64'h106,  64'h0,                1, 1'b0, 64'hFFFFFFFFFFFF8877,  1'b0, "lh_0x106"};
      t[5]  = '{1'b0, 64'h104,  64'h0,                2, 1'b1, 64'h88776655,          1'b0, "lwu_0x104"};
      t[6]  = '{1'b1, 64'h102,  64'hBEEF,             1, 1'b0, 64'h0,                 1'b0, "sh_0x102"};
      t[7]  = '{1'b0, 64'h100,  64'h0,                3, 1'b0, 64'h88776655BEEF2211,  1'b0, "ld_after_sh"};
      t[8]  = '{1'b0, 64'h102,  64'h0,                2, 1'b0, 64'h0,                 1'b1, "lw_misaligned"};
      t[9]  = '{1'b1, 64'h1000, 64'h1234567890ABCDEF, 3, 1'b0, 64'h0,                 1'b1, "sd_out_of_range"};
      t[10] = '{1'b0, 64'hFFC,  64'h0,                3, 1'b0, 64'h0,                 1'b1, "ld_misaligned_top"};
      foreach (t[i]) begin
         run_txn(t[i].we, t[i].addr, t[i].wdata, t[i].w, t[i].uns, t[i].name, rd, er);
         n_cmp++;
         if (rd !== t[i].exp_rdata || er !== t[i].exp_err) begin
            n_bad++;
            $display("FAIL %s const: got err=%b rdata=%h want err=%b rdata=%h",
                     t[i].name, er, rd, t[i].exp_err, t[i].exp_rdata);
         end
      end
      // Location 0 must be untouched by the out-of-range store (model unchanged).
      run_txn(1'b0, 64'h0, 64'h0, 3, 1'b0, "ld_0x000_no_alias", rd, er);
   endtask

   task automatic test_backpressure();
      logic        e_err;
      logic [63:0] e_rd;
      logic [63:0] rd;
      logic        er;
      bit          seen;
      model_access(1'b0, 64'h100, 64'h0, 3, 1'b0, e_err, e_rd);
      rsp_ready_i = 1'b0;
      @(negedge clk_i);
      drive_req(1'b0, 64'h100, 64'h0, 3, 1'b0);
      @(posedge clk_i);
      #1 req_valid_i = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_i);
         if (rsp_valid_o === 1'b1) begin
            seen = 1;
            break;
         end
      end
      n_cmp++;
      if (!seen) begin
         n_bad++;
         $display("FAIL bp_rsp_timeout: got no rsp_valid_o want 1");
      end
      // Hold off the response while offering a store that must be ignored.
      for (int c = 0; c < 5; c++) begin
         drive_req(1'b1, 64'h300, 64'hFFFF_FFFF_FFFF_FFFF, 3, 1'b0);
         n_cmp++;
         if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== e_rd || rsp_err_o !== 1'b0 || req_ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h err=%b ready=%b want 1 %h 0 0",
                     c, rsp_valid_o, rsp_rdata_o, rsp_err_o, req_ready_o, e_rd);
         end
         @(negedge clk_i);
      end
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      n_cmp++;
      if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_release: got ready=%b valid=%b want 1 0", req_ready_o, rsp_valid_o);
      end
      run_txn(1'b0, 64'h300, 64'h0, 3, 1'b0, "bp_ignored_store", rd, er);
   endtask

   task automatic test_reset_mid();
      logic [63:0] rd;
      logic        er;
      @(negedge clk_i);
      drive_req(1'b1, 64'h200, 64'hAAAA, 3, 1'b0);
      @(posedge clk_i);
      #1 req_valid_i = 1'b0;
      @(negedge clk_i);
      n_cmp++;
      if (req_ready_o !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mid_wait: got ready=%b want 0", req_ready_o);
      end
      rst_i = 1'b1;
      @(negedge clk_i);
      n_cmp++;
      if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || rsp_rdata_o !== 64'd0 || rsp_err_o !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mid_state: got valid=%b ready=%b rdata=%h err=%b want 0 1 0 0",
                  rsp_valid_o, req_ready_o, rsp_rdata_o, rsp_err_o);
      end
      rst_i = 1'b0;
      run_txn(1'b0, 64'h200, 64'h0, 3, 1'b0, "rst_store_discarded", rd, er);
   endtask

   task automatic test_random();
      logic [63:0] addr;
      logic [63:0] rd;
      logic        er;
      int          w;
      int          r;
      for (int i = 0; i < 80; i++) begin
         w = $urandom_range(0, 3);
         r = $urandom_range(0, 9);
         if (r == 0) begin
            addr = {$urandom, $urandom} | (64'd1 << $urandom_range(12, 63));
         end else begin
            addr = 64'($urandom_range(0, 1023));
            if (r < 8) addr = addr & ~64'((1 << w) - 1);
         end
         run_txn(1'($urandom_range(0, 1)), addr, {$urandom, $urandom}, w,
                 1'($urandom_range(0, 1)), "random", rd, er);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
